// File: rtl/lifo_port_arbiter_pkg.sv
// Shared types and width helpers for lifo_port_arbiter and its sub-blocks.
package lifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2
  } lifo_arb_state_t;

  localparam int unsigned N_DEF     = 3;
  localparam int unsigned W_DEF     = 10;
  localparam int unsigned DEPTH_DEF = 16;

  // Requester-id and occupancy widths for the default configuration.
  localparam int unsigned ID_W  = (N_DEF > 1) ? $clog2(N_DEF) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH_DEF + 1);

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_port_arbiter_if.sv
// Bundle of requester, response and lifo-side signals of lifo_port_arbiter.
// slave = arbiter view, master = requesters + lifo view.
// Optional high-water-mark port pair is present when LIFO_ARB_HWM_EN is defined.
interface lifo_port_arbiter_if
  import lifo_arb_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
);
  localparam int unsigned IW = id_width(N);
  localparam int unsigned LW = lvl_width(DEPTH);

  logic [N-1:0]         req;
  logic [N-1:0]         req_push;
  logic [N-1:0][W-1:0]  req_data;
  logic                 flush;
  logic [N-1:0]         gnt;
  logic                 rsp_valid;
  logic [W-1:0]         rsp_data;
  logic [IW-1:0]        rsp_id;
  logic                 rsp_err;
  logic                 busy;
  logic [LW-1:0]        level;
  logic                 lifo_write;
  logic                 lifo_read;
  logic [W-1:0]         lifo_datain;
  logic [W-1:0]         lifo_dataout;
  logic                 lifo_val;
  logic                 lifo_full;

`ifdef LIFO_ARB_HWM_EN
  logic [LW-1:0]        hwm;
  logic                 hwm_clr;

  modport slave (
    input  req, req_push, req_data, flush, lifo_dataout, lifo_val, lifo_full, hwm_clr,
    output gnt, rsp_valid, rsp_data, rsp_id, rsp_err, busy, level,
           lifo_write, lifo_read, lifo_datain, hwm
  );
  modport master (
    output req, req_push, req_data, flush, lifo_dataout, lifo_val, lifo_full, hwm_clr,
    input  gnt, rsp_valid, rsp_data, rsp_id, rsp_err, busy, level,
           lifo_write, lifo_read, lifo_datain, hwm
  );
`else
  modport slave (
    input  req, req_push, req_data, flush, lifo_dataout, lifo_val, lifo_full,
    output gnt, rsp_valid, rsp_data, rsp_id, rsp_err, busy, level,
           lifo_write, lifo_read, lifo_datain
  );
  modport master (
    output req, req_push, req_data, flush, lifo_dataout, lifo_val, lifo_full,
    input  gnt, rsp_valid, rsp_data, rsp_id, rsp_err, busy, level,
           lifo_write, lifo_read, lifo_datain
  );
`endif

endinterface

// File: rtl/lifo_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr_i.
module rr_arbiter
  import lifo_arb_pkg::*;
#(
  parameter  int unsigned N  = N_DEF,
  localparam int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  logic [IW-1:0] cand;

  // Scan requesters starting at the pointer; the first one found wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = IW'((32'(ptr_i) + off) % N);
      if (!vld_o && req_i[cand]) begin
        vld_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lifo_port_arbiter.sv
// lifo_port_arbiter: shares one lifo among N requesters with round-robin grants,
// its own occupancy count, tagged pop responses and a bulk flush.
// Optional feature macro: LIFO_ARB_HWM_EN adds hwm/hwm_clr (max level since reset).
module lifo_port_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  lifo_port_arbiter_if.slave   arb
);

  localparam int unsigned   IW      = id_width(N);
  localparam int unsigned   LW      = lvl_width(DEPTH);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE = LW'(1);

  lifo_arb_state_t state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   op_id_q, op_id_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic            lifo_write_q, lifo_write_d;
  logic            lifo_read_q, lifo_read_d;
  logic [W-1:0]    lifo_datain_q, lifo_datain_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [W-1:0]    rsp_data_q, rsp_data_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic [LW-1:0]   level_q, level_d;
  logic [LW-1:0]   flush_lvl;

  logic [N-1:0]    win_gnt;
  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic            full_i, empty_i;

  // Either our own count or the lifo's flags may declare full/empty; trust the stricter one.
  assign full_i  = (level_q == LVL_MAX) | arb.lifo_full;
  assign empty_i = (level_q == '0) | !arb.lifo_val;
  assign busy_d  = (state_d != IDLE);

  rr_arbiter #(.N(N)) u_rr (
    .req_i (arb.req),
    .ptr_i (ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx),
    .vld_o (win_vld)
  );

  // Next-state and registered-output decisions for the IDLE/ISSUE/FLUSH sequencer.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    op_id_d       = op_id_q;
    gnt_d         = '0;
    lifo_write_d  = 1'b0;
    lifo_read_d   = 1'b0;
    lifo_datain_d = '0;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_id_d      = rsp_id_q;
    rsp_err_d     = 1'b0;
    level_d       = level_q;
    flush_lvl     = level_q;
    case (state_q)
      IDLE: begin
        if (arb.flush) begin
          // Flush wins over requests; they simply stay pending.
          state_d     = FLUSH;
          lifo_read_d = !empty_i;
        end else if (win_vld) begin
          state_d = ISSUE;
          gnt_d   = win_gnt;
          op_id_d = win_idx;
          ptr_d   = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
          if (arb.req_push[win_idx] && !full_i) begin
            lifo_write_d  = 1'b1;
            lifo_datain_d = arb.req_data[win_idx];
          end else if (!arb.req_push[win_idx] && !empty_i) begin
            lifo_read_d = 1'b1;
          end else begin
            rsp_err_d = 1'b1;
            rsp_id_d  = win_idx;
          end
        end
      end
      ISSUE: begin
        // The lifo acts on the strobes at the end of this cycle; the count follows it.
        state_d = IDLE;
        if (lifo_write_q && level_q != LVL_MAX) begin
          level_d = level_q + LVL_ONE;
        end
        if (lifo_read_q) begin
          if (level_q != '0) begin
            level_d = level_q - LVL_ONE;
          end
          rsp_valid_d = 1'b1;
          rsp_data_d  = arb.lifo_dataout;
          rsp_id_d    = op_id_q;
        end
      end
      FLUSH: begin
        // Account for the read in flight before deciding whether another is needed.
        if (lifo_read_q && level_q != '0) begin
          flush_lvl = level_q - LVL_ONE;
        end
        level_d = flush_lvl;
        if (flush_lvl != '0 && arb.lifo_val) begin
          lifo_read_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything, dropping any pending response.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      op_id_q       <= '0;
      gnt_q         <= '0;
      lifo_write_q  <= 1'b0;
      lifo_read_q   <= 1'b0;
      lifo_datain_q <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      level_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      op_id_q       <= op_id_d;
      gnt_q         <= gnt_d;
      lifo_write_q  <= lifo_write_d;
      lifo_read_q   <= lifo_read_d;
      lifo_datain_q <= lifo_datain_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_id_q      <= rsp_id_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      level_q       <= level_d;
    end
  end

  assign arb.gnt         = gnt_q;
  assign arb.rsp_valid   = rsp_valid_q;
  assign arb.rsp_data    = rsp_data_q;
  assign arb.rsp_id      = rsp_id_q;
  assign arb.rsp_err     = rsp_err_q;
  assign arb.busy        = busy_q;
  assign arb.level       = level_q;
  assign arb.lifo_write  = lifo_write_q;
  assign arb.lifo_read   = lifo_read_q;
  assign arb.lifo_datain = lifo_datain_q;

`ifdef LIFO_ARB_HWM_EN
  logic          lvl_inc_q;
  logic [LW-1:0] hwm_q, hwm_d;

  // Clear wins unless the level has just risen, in which case the new level is taken.
  always_comb begin
    hwm_d = arb.hwm_clr ? '0 : hwm_q;
    if (lvl_inc_q && level_q > hwm_d) begin
      hwm_d = level_q;
    end
  end

  // High-water-mark register, one cycle behind the level it tracks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl_inc_q <= 1'b0;
      hwm_q     <= '0;
    end else begin
      lvl_inc_q <= (level_d > level_q);
      hwm_q     <= hwm_d;
    end
  end

  assign arb.hwm = hwm_q;
`endif

endmodule
